// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Sequences runs of an externally attached counter. An accepted start
//   clears the counter for one cycle, then enables it until it reaches the
//   latched period. A one-cycle done pulse follows, and in periodic mode
//   the run repeats. A start with a zero period is rejected and answered
//   with an err pulse.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   start      in   request a run (ignored while busy)
//   stop       in   abort the current run
//   mode       in   0 = one-shot, 1 = periodic
//   period     in   terminal count, latched on an accepted start
//   cnt_value  in   current value of the attached counter
//   cnt_clear  out  synchronous clear command to the counter
//   cnt_enable out  increment enable to the counter
//   busy       out  high whenever the sequencer is not idle
//   done       out  one-cycle pulse at the end of each completed run
//   err        out  one-cycle pulse after a rejected start
//   runs       out  completed runs since reset, wraps 255 -> 0
module counter_sequencer #(
    parameter int BIT_SZ = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              mode,
    input  logic [BIT_SZ-1:0] period,
    input  logic [BIT_SZ-1:0] cnt_value,
    output logic              cnt_clear,
    output logic              cnt_enable,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        runs
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [BIT_SZ-1:0] period_q;
    logic [BIT_SZ-1:0] period_d;
    logic              mode_q;
    logic              mode_d;
    logic [7:0]        runs_q;
    logic [7:0]        runs_d;
    logic              err_q;
    logic              err_d;
    logic              at_terminal_s;

    assign at_terminal_s = (cnt_value == period_q);

    // State and run-parameter registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            period_q <= '0;
            mode_q   <= 1'b0;
            runs_q   <= 8'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            mode_q   <= mode_d;
            runs_q   <= runs_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic; stop always wins over terminal detection and looping.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        mode_d   = mode_q;
        runs_d   = runs_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // start together with stop is treated as a plain stop.
                if (start && !stop) begin
                    if (period != '0) begin
                        state_d  = CLEAR;
                        period_d = period;
                        mode_d   = mode;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (stop) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (at_terminal_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                // The run has completed even if stop arrives now.
                runs_d = runs_q + 8'd1;
                if (stop || !mode_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore outputs come from registered state; only cnt_enable looks at inputs.
    assign cnt_clear  = (state_q == CLEAR);
    assign cnt_enable = (state_q == RUN) && !stop && !at_terminal_s;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign err        = err_q;
    assign runs       = runs_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic        mode;
    logic [15:0] period;
    logic [15:0] cnt_value;
    logic        cnt_clear;
    logic        cnt_enable;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  runs;

    counter_sequencer #(.BIT_SZ(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .period     (period),
        .cnt_value  (cnt_value),
        .cnt_clear  (cnt_clear),
        .cnt_enable (cnt_enable),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .runs       (runs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Attached counter, behaving as the contract describes.
    initial cnt_value = 16'd0;
    always @(posedge clock) begin
        if (cnt_clear) cnt_value <= 16'd0;
        else if (cnt_enable) cnt_value <= cnt_value + 16'd1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: a run is a timeline, t counts cycles since acceptance.
    // t=1 clear, t=2..p+2 counting (value t-2), t=p+3 done.
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_p      = 0;
    bit m_m      = 1'b0;
    int m_runs   = 0;
    bit m_err    = 1'b0;

    int cyc        = 0;
    int last_done  = -100;
    int prev_done  = -100;
    int done_count = 0;
    int obs_runs   = 0;
    int obs_busy   = 0;
    int obs_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_runs   = 0;
        m_err    = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit s, input bit sp, input bit md, input int per);
        bit e_clear, e_run, e_en, e_done;
        @(negedge clock);
        start  = s;
        stop   = sp;
        mode   = md;
        period = per[15:0];
        #1;
        e_clear = m_active && (m_t == 1);
        e_run   = m_active && (m_t >= 2) && (m_t <= m_p + 2);
        e_en    = e_run && !sp && ((m_t - 2) < m_p);
        e_done  = m_active && (m_t == m_p + 3);
        chk("busy",       int'(busy),       int'(m_active));
        chk("cnt_clear",  int'(cnt_clear),  int'(e_clear));
        chk("cnt_enable", int'(cnt_enable), int'(e_en));
        chk("done",       int'(done),       int'(e_done));
        chk("err",        int'(err),        int'(m_err));
        chk("runs",       int'(runs),       m_runs);
        if (e_run) chk("cnt_value", int'(cnt_value), m_t - 2);
        if (done === 1'b1) begin
            prev_done = last_done;
            last_done = cyc;
            done_count++;
        end
        obs_runs = int'(runs);
        obs_busy = int'(busy);
        obs_err  = int'(err);
        @(posedge clock);
        m_err = !m_active && s && !sp && (per == 0);
        if (!m_active) begin
            if (s && !sp && per != 0) begin
                m_active = 1'b1;
                m_t      = 1;
                m_p      = per;
                m_m      = md;
            end
        end else if (m_t == m_p + 3) begin
            m_runs = (m_runs + 1) % 256;
            if (sp || !m_m) m_active = 1'b0;
            else m_t = 1;
        end else if (sp) begin
            m_active = 1'b0;
        end else begin
            m_t++;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0);
    endtask

    // Reset asserted between edges: outputs must drop at once.
    task automatic mid_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy",   int'(busy),       0);
        chk("rst_done",   int'(done),       0);
        chk("rst_err",    int'(err),        0);
        chk("rst_clear",  int'(cnt_clear),  0);
        chk("rst_enable", int'(cnt_enable), 0);
        chk("rst_runs",   int'(runs),       0);
        model_reset();
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    initial begin
        int s_idx;
        int dc;
        reset  = 1'b1;
        start  = 1'b0;
        stop   = 1'b0;
        mode   = 1'b0;
        period = 16'd0;
        #2;
        chk("init_busy", int'(busy), 0);
        chk("init_runs", int'(runs), 0);
        chk("init_done", int'(done), 0);
        model_reset();
        @(posedge clock);
        #2 reset = 1'b0;

        // One-shot, period 3: done six cycles after the start cycle.
        idle(2);
        s_idx = cyc;
        step(1'b1, 1'b0, 1'b0, 3);
        idle(8);
        chk("s1_latency", last_done - s_idx, 6);
        chk("s1_runs", obs_runs, 1);
        chk("s1_idle", obs_busy, 0);

        // Periodic, period 2: done every 5 cycles, then stop.
        dc = done_count;
        step(1'b1, 1'b0, 1'b1, 2);
        idle(15);
        chk("s2_done_count", done_count - dc, 3);
        chk("s2_interval", last_done - prev_done, 5);
        step(1'b0, 1'b1, 1'b0, 2);
        dc = done_count;
        idle(8);
        chk("s2_no_done_after_stop", done_count - dc, 0);
        chk("s2_runs", obs_runs, 4);
        chk("s2_idle", obs_busy, 0);

        // Zero period is rejected.
        step(1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 1'b0, 0);
        chk("s3_err", obs_err, 1);
        chk("s3_busy", obs_busy, 0);
        idle(2);

        // Start with a new period during RUN is ignored.
        s_idx = cyc;
        step(1'b1, 1'b0, 1'b0, 5);
        step(1'b0, 1'b0, 1'b0, 5);
        step(1'b0, 1'b0, 1'b0, 5);
        step(1'b1, 1'b0, 1'b1, 9);
        idle(8);
        chk("s4_latency", last_done - s_idx, 8);
        chk("s4_runs", obs_runs, 5);

        // Reset in the middle of a run, then a normal run.
        step(1'b1, 1'b0, 1'b0, 5);
        idle(3);
        dc = done_count;
        mid_reset();
        chk("s5_no_done_from_reset", done_count - dc, 0);
        s_idx = cyc;
        step(1'b1, 1'b0, 1'b0, 2);
        idle(6);
        chk("s5_latency", last_done - s_idx, 5);
        chk("s5_runs", obs_runs, 1);

        // 256 one-shot runs wrap the run counter.
        mid_reset();
        dc = done_count;
        for (int r = 0; r < 256; r++) begin
            step(1'b1, 1'b0, 1'b0, 1);
            idle(4);
        end
        idle(1);
        chk("s6_done_count", done_count - dc, 256);
        chk("s6_runs_wrap", obs_runs, 0);

        // Stop in the cycle the counter reaches the period: no done.
        dc = done_count;
        step(1'b1, 1'b0, 1'b0, 3);
        idle(4);
        step(1'b0, 1'b1, 1'b0, 3);
        idle(6);
        chk("s7_no_done", done_count - dc, 0);
        chk("s7_runs", obs_runs, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            bit rs, rp, rm;
            int per;
            rs  = ($urandom_range(3, 0) == 0);
            rp  = ($urandom_range(15, 0) == 0);
            rm  = $urandom_range(1, 0) == 1;
            per = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(6, 1));
            step(rs, rp, rm, per);
            if ($urandom_range(299, 0) == 0) mid_reset();
        end
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
